// File: rtl/uarch_pkg.sv
// Shared micro-architecture widths and the AGU store write-back packet.
package uarch_pkg;

   localparam int TAG_WIDTH      = 8;
   localparam int PIPE_WIDTH     = 2;
   localparam int CPU_ADDR_BITS  = 32;
   localparam int SB_ENTRIES_DEF = 8;

   typedef struct packed {
      logic                     is_valid;
      logic [TAG_WIDTH-1:0]     tag;
      logic [CPU_ADDR_BITS-1:0] addr;
      logic [31:0]              data;
      logic [3:0]               be;
   } store_wb_packet_t;

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer: dispatch-order allocate, AGU fill, ROB commit,
// in-order drain to the D-cache, and flush of uncommitted stores.
module store_buffer
   import uarch_pkg::*;
#(
   parameter int SB_ENTRIES = SB_ENTRIES_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic [PIPE_WIDTH-1:0]                 sb_alloc_req,
   output logic [PIPE_WIDTH-1:0]                 sb_alloc_gnt,
   input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  sb_alloc_tags,
   input  store_wb_packet_t                      st_wb,
   input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  commit_store_ids,
   input  logic [PIPE_WIDTH-1:0]                 commit_store_vals,
   output logic                                  mem_req_valid,
   output logic [CPU_ADDR_BITS-1:0]              mem_req_addr,
   output logic [31:0]                           mem_req_data,
   output logic [3:0]                            mem_req_be,
   input  logic                                  mem_req_ready,
   output logic                                  sb_empty,
   output logic [$clog2(SB_ENTRIES):0]           sb_pending
);

   localparam int PTR = $clog2(SB_ENTRIES);

   typedef logic [PTR:0]   ptr_t;
   typedef logic [PTR-1:0] idx_t;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]     tag;
      logic [CPU_ADDR_BITS-1:0] addr;
      logic [31:0]              data;
      logic [3:0]               be;
      logic                     valid;
      logic                     filled;
      logic                     committed;
   } sb_entry_t;

   sb_entry_t r_ent [SB_ENTRIES];
   ptr_t      r_head;
   ptr_t      r_cmt;
   ptr_t      r_tail;

   ptr_t                  w_used;
   ptr_t                  w_free;
   ptr_t                  w_ncmt;
   ptr_t                  w_cmt_nxt;
   ptr_t                  w_live;
   ptr_t                  w_nalloc;
   idx_t                  w_head_idx;
   idx_t                  w_cidx [PIPE_WIDTH];
   idx_t                  w_aidx [PIPE_WIDTH];
   idx_t                  w_dist;
   sb_entry_t             w_new  [PIPE_WIDTH];
   logic [PIPE_WIDTH-1:0] w_gnt;
   logic [SB_ENTRIES-1:0] w_kill;
   logic                  w_drain;

   // Free space is taken from registered pointers only; a drain this
   // cycle does not lend its slot to this cycle's allocation.
   assign w_used     = r_tail - r_head;
   assign w_free     = ptr_t'(SB_ENTRIES) - w_used;
   assign w_head_idx = r_head[PTR-1:0];

   always_comb begin
      w_gnt = '0;
      if (rst && !flush) begin
         w_gnt[0] = sb_alloc_req[0] && (w_free >= ptr_t'(1));
         w_gnt[1] = sb_alloc_req[1] &&
                    (w_free >= (sb_alloc_req[0] ? ptr_t'(2) : ptr_t'(1)));
      end
   end

   assign sb_alloc_gnt = w_gnt;
   assign w_nalloc     = ptr_t'(w_gnt[0]) + ptr_t'(w_gnt[1]);

   assign w_ncmt    = ptr_t'(commit_store_vals[0]) +
                      ptr_t'(commit_store_vals[1]);
   assign w_cmt_nxt = r_cmt + w_ncmt;
   assign w_live    = r_tail - w_cmt_nxt;

   assign w_cidx[0] = r_cmt[PTR-1:0];
   assign w_cidx[1] = r_cmt[PTR-1:0] + idx_t'(commit_store_vals[0]);
   assign w_aidx[0] = r_tail[PTR-1:0];
   assign w_aidx[1] = r_tail[PTR-1:0] + idx_t'(w_gnt[0]);

   always_comb begin
      for (int s = 0; s < PIPE_WIDTH; s++) begin
         w_new[s]       = '0;
         w_new[s].tag   = sb_alloc_tags[s];
         w_new[s].valid = 1'b1;
      end
   end

   // Entries from the post-commit cmt up to tail are discarded on flush.
   always_comb begin
      w_kill = '0;
      w_dist = '0;
      for (int i = 0; i < SB_ENTRIES; i++) begin
         w_dist    = idx_t'(i) - w_cmt_nxt[PTR-1:0];
         w_kill[i] = ({1'b0, w_dist} < w_live);
      end
   end

   assign mem_req_valid = (r_head != r_cmt);
   assign mem_req_addr  = r_ent[w_head_idx].addr;
   assign mem_req_data  = r_ent[w_head_idx].data;
   assign mem_req_be    = r_ent[w_head_idx].be;
   assign w_drain       = mem_req_valid && mem_req_ready;

   assign sb_empty   = (r_head == r_tail);
   assign sb_pending = r_cmt - r_head;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= '0;
         r_cmt  <= '0;
         r_tail <= '0;
         for (int i = 0; i < SB_ENTRIES; i++) begin
            r_ent[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SB_ENTRIES; i++) begin
            if (st_wb.is_valid && !flush && r_ent[i].valid &&
                !r_ent[i].filled && r_ent[i].tag == st_wb.tag) begin
               r_ent[i].filled <= 1'b1;
               r_ent[i].addr   <= st_wb.addr;
               r_ent[i].data   <= st_wb.data;
               r_ent[i].be     <= st_wb.be;
            end
            if (flush && w_kill[i]) begin
               r_ent[i].valid <= 1'b0;
            end
         end
         for (int s = 0; s < PIPE_WIDTH; s++) begin
            if (commit_store_vals[s]) begin
               assert (r_ent[w_cidx[s]].valid &&
                       r_ent[w_cidx[s]].filled &&
                       r_ent[w_cidx[s]].tag == commit_store_ids[s])
                  else $error("store commit tag/fill error slot %0d", s);
               r_ent[w_cidx[s]].committed <= 1'b1;
            end
            if (w_gnt[s]) begin
               r_ent[w_aidx[s]] <= w_new[s];
            end
         end
         if (w_drain) begin
            r_ent[w_head_idx].valid     <= 1'b0;
            r_ent[w_head_idx].filled    <= 1'b0;
            r_ent[w_head_idx].committed <= 1'b0;
            r_head                      <= r_head + ptr_t'(1);
         end
         r_cmt  <= w_cmt_nxt;
         r_tail <= flush ? w_cmt_nxt : r_tail + w_nalloc;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue model
// that tracks stores from oldest to youngest.
module tb_store_buffer;
   import uarch_pkg::*;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush;
   logic [PIPE_WIDTH-1:0]                req;
   logic [PIPE_WIDTH-1:0]                gnt;
   logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] tags;
   store_wb_packet_t                     wb;
   logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] cids;
   logic [PIPE_WIDTH-1:0]                cvals;
   logic                                 mvalid;
   logic [CPU_ADDR_BITS-1:0]             maddr;
   logic [31:0]                          mdata;
   logic [3:0]                           mbe;
   logic                                 ready;
   logic                                 empty;
   logic [$clog2(N):0]                   pend;

   always #5 clk = ~clk;

   store_buffer #(.SB_ENTRIES(N)) dut (
      .clk               (clk),
      .rst               (rst),
      .flush             (flush),
      .sb_alloc_req      (req),
      .sb_alloc_gnt      (gnt),
      .sb_alloc_tags     (tags),
      .st_wb             (wb),
      .commit_store_ids  (cids),
      .commit_store_vals (cvals),
      .mem_req_valid     (mvalid),
      .mem_req_addr      (maddr),
      .mem_req_data      (mdata),
      .mem_req_be        (mbe),
      .mem_req_ready     (ready),
      .sb_empty          (empty),
      .sb_pending        (pend)
   );

   typedef struct {
      logic [TAG_WIDTH-1:0] tag;
      bit                   filled;
      logic [31:0]          addr;
      logic [31:0]          data;
      logic [3:0]           be;
   } m_t;

   m_t   q[$];
   int   ncmt;
   int   n_chk;
   int   n_pass;
   int   n_fail;
   logic [7:0] tagctr;

   task automatic chk(input string nm, input logic [63:0] o,
                      input logic [63:0] e);
      n_chk++;
      assert (o === e) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
      end
   endtask

   task automatic idle();
      flush = 1'b0;
      req   = '0;
      tags  = '0;
      wb    = '0;
      cids  = '0;
      cvals = '0;
      ready = 1'b0;
   endtask

   function automatic bit in_q(input logic [7:0] t);
      foreach (q[i]) if (q[i].tag == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int avail();
      int k = 0;
      while (k < 2 && ncmt + k < q.size() && q[ncmt+k].filled) k++;
      return k;
   endfunction

   task automatic set_commit(input int n);
      for (int s = 0; s < n; s++) begin
         cvals[s] = 1'b1;
         cids[s]  = q[ncmt+s].tag;
      end
   endtask

   // Check outputs against the model, advance the model, then clock.
   task automatic cycle();
      logic [1:0] eg;
      int         fr;
      bit         mv;
      #1;
      fr    = N - q.size();
      eg[0] = !flush && req[0] && fr >= 1;
      eg[1] = !flush && req[1] && (req[0] ? fr >= 2 : fr >= 1);
      mv    = ncmt > 0;
      chk("gnt", 64'(gnt), 64'(eg));
      chk("mvalid", 64'(mvalid), 64'(mv));
      if (mv) begin
         chk("maddr", 64'(maddr), 64'(q[0].addr));
         chk("mdata", 64'(mdata), 64'(q[0].data));
         chk("mbe", 64'(mbe), 64'(q[0].be));
      end
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("pending", 64'(pend), 64'(ncmt));
      for (int s = 0; s < 2; s++) if (cvals[s]) ncmt++;
      if (wb.is_valid && !flush) begin
         foreach (q[i]) begin
            if (!q[i].filled && q[i].tag == wb.tag) begin
               q[i].filled = 1'b1;
               q[i].addr   = wb.addr;
               q[i].data   = wb.data;
               q[i].be     = wb.be;
            end
         end
      end
      if (flush) begin
         while (q.size() > ncmt) void'(q.pop_back());
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (eg[s]) q.push_back('{tags[s], 1'b0, '0, '0, '0});
         end
      end
      if (mv && ready) begin
         void'(q.pop_front());
         ncmt--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      req = 2'b11;
      #1;
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_mvalid", 64'(mvalid), 64'(0));
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_pend", 64'(pend), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      q.delete();
      ncmt = 0;
   endtask

   task automatic alloc2(input logic [1:0] r, input logic [7:0] t0,
                         input logic [7:0] t1);
      idle();
      req     = r;
      tags[0] = t0;
      tags[1] = t1;
      cycle();
   endtask

   task automatic fill(input logic [7:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
      idle();
      wb.is_valid = 1'b1;
      wb.tag      = t;
      wb.addr     = a;
      wb.data     = d;
      wb.be       = b;
      cycle();
   endtask

   task automatic commit(input int n);
      idle();
      set_commit(n);
      cycle();
   endtask

   initial begin
      logic [1:0] r;
      int         uf[$];
      int         j;
      n_chk  = 0;
      n_pass = 0;
      n_fail = 0;
      ncmt   = 0;
      tagctr = 8'd100;
      idle();
      #1;

      // two stores filled out of order, committed together, drained in order
      do_reset();
      alloc2(2'b11, 8'd3, 8'd4);
      fill(8'd4, 32'h400, 32'h4444_4444, 4'h3);
      fill(8'd3, 32'h300, 32'h3333_3333, 4'hF);
      idle();
      set_commit(2);
      ready = 1'b1;
      cycle();
      idle();
      ready = 1'b1;
      #1;
      chk("t031_addr3", 64'(maddr), 64'h300);
      chk("t031_data3", 64'(mdata), 64'h3333_3333);
      cycle();
      idle();
      ready = 1'b1;
      #1;
      chk("t031_addr4", 64'(maddr), 64'h400);
      chk("t031_be4", 64'(mbe), 64'h3);
      cycle();
      #1;
      chk("t031_empty", 64'(empty), 64'(1));

      // full buffer refuses allocation; a same-cycle drain gives no credit
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc2(2'b11, 8'(10 + 2 * i), 8'(11 + 2 * i));
      end
      fill(8'd10, 32'hA0, 32'h1010_1010, 4'hF);
      commit(1);
      idle();
      req  = 2'b11;
      tags = {8'd51, 8'd50};
      #1;
      chk("t032_full", 64'(gnt), 64'(0));
      cycle();
      idle();
      req   = 2'b11;
      tags  = {8'd51, 8'd50};
      ready = 1'b1;
      #1;
      chk("t032_drain_cyc", 64'(gnt), 64'(0));
      cycle();
      idle();
      req  = 2'b11;
      tags = {8'd51, 8'd50};
      #1;
      chk("t032_next", 64'(gnt), 64'(2'b01));
      cycle();

      // flush with a same-cycle commit of the third entry
      do_reset();
      alloc2(2'b11, 8'd20, 8'd21);
      alloc2(2'b11, 8'd22, 8'd23);
      alloc2(2'b01, 8'd24, 8'd0);
      for (int i = 0; i < 5; i++) begin
         fill(8'(20 + i), 32'(32'h2000 + i), 32'(32'h5000 + i), 4'hF);
      end
      commit(2);
      idle();
      flush    = 1'b1;
      cvals[0] = 1'b1;
      cids[0]  = 8'd22;
      req      = 2'b11;
      tags     = {8'd61, 8'd60};
      cycle();
      #1;
      chk("t033_pend", 64'(pend), 64'(3));
      chk("t033_notempty", 64'(empty), 64'(0));
      fill(8'd23, 32'hBAD, 32'hBAD, 4'hF);
      for (int i = 0; i < 3; i++) begin
         idle();
         ready = 1'b1;
         cycle();
      end
      #1;
      chk("t033_gone", 64'(empty), 64'(1));

      // stall: request fields hold while ready is low
      do_reset();
      alloc2(2'b01, 8'd30, 8'd0);
      fill(8'd30, 32'h1000, 32'hDEAD_BEEF, 4'hF);
      commit(1);
      for (int i = 0; i < 4; i++) begin
         idle();
         #1;
         chk("t034_addr", 64'(maddr), 64'h1000);
         chk("t034_data", 64'(mdata), 64'hDEAD_BEEF);
         chk("t034_be", 64'(mbe), 64'hF);
         chk("t034_pend", 64'(pend), 64'(1));
         cycle();
      end
      idle();
      ready = 1'b1;
      cycle();
      #1;
      chk("t034_retired", 64'(pend), 64'(0));
      chk("t034_empty", 64'(empty), 64'(1));

      // randomized traffic, wraps the pointers many times
      do_reset();
      for (int c = 0; c < 300; c++) begin
         idle();
         r       = 2'($urandom_range(0, 3));
         tags[0] = tagctr;
         tags[1] = tagctr + 8'd1;
         tagctr  = tagctr + 8'd2;
         if (in_q(tags[0])) r[0] = 1'b0;
         if (in_q(tags[1])) r[1] = 1'b0;
         req = r;
         uf.delete();
         foreach (q[i]) if (!q[i].filled) uf.push_back(i);
         if ($urandom_range(0, 3) != 0 && uf.size() > 0) begin
            j           = uf[$urandom_range(0, uf.size() - 1)];
            wb.is_valid = 1'b1;
            wb.tag      = q[j].tag;
            wb.addr     = $urandom;
            wb.data     = $urandom;
            wb.be       = 4'($urandom);
         end else if (!in_q(tagctr + 8'h80)) begin
            wb.is_valid = 1'b1;
            wb.tag      = tagctr + 8'h80;
            wb.data     = $urandom;
         end
         set_commit($urandom_range(0, avail()));
         ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      for (int c = 0; c < 200 && q.size() > 0; c++) begin
         idle();
         foreach (q[i]) begin
            if (!q[i].filled && !wb.is_valid) begin
               wb.is_valid = 1'b1;
               wb.tag      = q[i].tag;
               wb.addr     = $urandom;
               wb.data     = $urandom;
               wb.be       = 4'($urandom);
            end
         end
         set_commit(avail());
         ready = 1'b1;
         cycle();
      end
      #1;
      chk("rand_drained", 64'(empty), 64'(1));

      // reset mid-drain drops the request asynchronously
      alloc2(2'b01, 8'd40, 8'd0);
      fill(8'd40, 32'h4000, 32'h4040_4040, 4'h1);
      commit(1);
      idle();
      #1;
      chk("t036_pre", 64'(mvalid), 64'(1));
      #1;
      rst = 1'b0;
      req = 2'b11;
      #1;
      chk("t036_mvalid", 64'(mvalid), 64'(0));
      chk("t036_empty", 64'(empty), 64'(1));
      chk("t036_pend", 64'(pend), 64'(0));
      chk("t036_gnt", 64'(gnt), 64'(0));
      q.delete();
      ncmt = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      alloc2(2'b11, 8'd41, 8'd42);
      alloc2(2'b11, 8'd43, 8'd44);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter SB_ENTRIES, default 8 (power of two, ≥4), giving the store-entry count.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous and active-low; the block is held in reset while rst=0.
REQ-004 The block SHALL have port flush, input, 1, the ROB pipeline flush.
REQ-005 The block SHALL have ports sb_alloc_req, input, PIPE_WIDTH, and sb_alloc_gnt, output, PIPE_WIDTH, for dispatch-order store allocation; slot 0 is older.
REQ-006 The block SHALL have port sb_alloc_tags, input, TAG_WIDTH x PIPE_WIDTH, the ROB tag of each allocating store.
REQ-007 The block SHALL have port st_wb, input, store_wb_packet_t, the AGU fill: is_valid, tag, addr[CPU_ADDR_BITS], data[32], be[4].
REQ-008 The block SHALL have ports commit_store_ids, input, TAG_WIDTH x PIPE_WIDTH, and commit_store_vals, input, PIPE_WIDTH, the ROB store-commit notifications.
REQ-009 The block SHALL have ports mem_req_valid, output, 1; mem_req_addr, output, CPU_ADDR_BITS; mem_req_data, output, 32; mem_req_be, output, 4; and mem_req_ready, input, 1, the D-cache write request.
REQ-010 The block SHALL have ports sb_empty, output, 1, (no entries) and sb_pending, output, $clog2(SB_ENTRIES)+1, (committed but not yet drained count).

Function
REQ-011 The block SHALL be a circular buffer with three (PTR+1)-bit pointers: head (oldest), cmt (oldest uncommitted), tail (next free), ordered head ≤ cmt ≤ tail modulo wrap; the MSB disambiguates full and empty.
REQ-012 The block SHALL compute free = SB_ENTRIES − (tail − head) from registered pointers only, with no same-cycle credit from drain.
REQ-013 The block SHALL drive sb_alloc_gnt[0] = req[0] && free≥1, and sb_alloc_gnt[1] = req[1] && (req[0] ? free≥2 : free≥1).
REQ-014 The block SHALL write each granted slot at the tail in slot order, storing tag, filled=0 and committed=0, and advance tail by the grant count.
REQ-015 On st_wb.is_valid, the block SHALL associatively match the tag against valid, unfilled entries and set filled, addr, data and be; a tag miss is ignored.
REQ-016 Each asserted commit_store_vals[i] SHALL mark the entry at cmt+i committed, with at most 2 per cycle in slot order; the stored tag must equal commit_store_ids[i], and a mismatch or an unfilled entry is an assertion failure.
REQ-017 The block SHALL drive mem_req_valid = (head≠cmt), with the head entry's addr, data and be; the outputs are combinational from registers.
REQ-018 When mem_req_valid && mem_req_ready, the block SHALL retire the head entry and advance head by 1; at most one drain per cycle.
REQ-019 While mem_req_valid=1 and ready=0, the request fields SHALL remain stable.
REQ-020 On flush, the block SHALL first apply same-cycle commits, then set tail := the new cmt and clear valid on all discarded entries.
REQ-021 In a flush cycle, the block SHALL ignore allocation, drive sb_alloc_gnt=0, and ignore st_wb.
REQ-022 Flush SHALL NOT stop the drain: committed entries keep draining, and a handshake in the flush cycle retires normally.
REQ-023 Drain, commit, allocation and fill SHALL be able to occur in the same cycle, including when the buffer wraps.
REQ-024 The block SHALL drive sb_empty = (head==tail) and sb_pending = cmt − head.

Reset
REQ-025 While rst=0, the block SHALL hold head=cmt=tail=0, clear all valid, filled and committed bits, and drive mem_req_valid=0, sb_alloc_gnt=0, sb_empty=1 and sb_pending=0.
REQ-026 A reset asserted mid-drain SHALL drop mem_req_valid asynchronously, and the entry SHALL be lost.
REQ-027 Data, address and be storage SHALL NOT need reset.

Structure
REQ-028 store_wb_packet_t and SB_ENTRIES' default SHALL live in uarch_pkg, alongside TAG_WIDTH, PIPE_WIDTH and CPU_ADDR_BITS.
REQ-029 The per-entry struct (tag, addr, data, be, valid, filled, committed) SHALL be local to store_buffer.
REQ-030 A sub-module is not required; tag-match logic is an inline loop.

Verification
REQ-031 Allocate 2 stores with tags 3 and 4, fill tag 4 then tag 3, commit both in one cycle, and hold ready=1; mem_req SHALL present tag 3's addr/data, then tag 4's, on consecutive cycles, then sb_empty=1.
REQ-032 Allocate 8 stores, then request 2 more; gnt SHALL be 00. Drain one with ready=1 in the same cycle as the request; gnt SHALL be 00 that cycle and 01 the next.
REQ-033 With 5 entries of which 2 are committed, assert flush together with a commit of the 3rd; tail SHALL become head+3, sb_pending=3, and the remaining 2 entries SHALL be gone.
REQ-034 Hold ready=0 for 4 cycles with a committed head (addr 0x1000, data 0xDEADBEEF, be 0xF); the outputs SHALL be stable and head SHALL stay unchanged; when ready=1, one retire.
REQ-035 Run 20 alloc/fill/commit/drain cycles to wrap the pointers twice; all stores SHALL drain in allocation order with no loss or duplication.
REQ-036 Drop rst while mem_req_valid=1; mem_req_valid SHALL be 0 in the same cycle, before any clock edge, and all pointers SHALL be 0.
